// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store sequencer.
//   SIZE_*      : access size codes as seen on req_size / mem_size
//   BEAT_W      : width of the beat counter (up to 4 byte beats)
//   state_e     : sequencer FSM encoding
//   req_t       : latched request
//   misaligned(): alignment test for a half/word access
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'd0;
  localparam logic [1:0] SIZE_HALF    = 2'd1;
  localparam logic [1:0] SIZE_ILLEGAL = 2'd2;
  localparam logic [1:0] SIZE_WORD    = 2'd3;

  localparam int BEAT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        write;
    logic        sgn;
  } req_t;

  // Byte accesses are always aligned; illegal size is handled separately.
  function automatic logic misaligned(input logic [1:0] a, input logic [1:0] size);
    return ((size == SIZE_HALF) && a[0]) || ((size == SIZE_WORD) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: merges the lane(s) of the current memory read word into the
// partially assembled load result and sign-/zero-extends the merged value.
//   mem_rdata : aligned word containing the current beat address
//   lane      : byte offset of the current beat address within that word
//   beat      : beat index (result byte position for split accesses)
//   split     : 1 = byte beat of a split access
//   size/sgn  : original request size and sign-extend flag
//   acc_in    : result assembled by earlier beats
//   acc_out   : result including this beat (raw, unextended)
//   ext_out   : acc_out extended to 32 bits by size/sgn
module load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  beat,
  input  logic        split,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] acc_in,
  output logic [31:0] acc_out,
  output logic [31:0] ext_out
);

  always_comb begin
    acc_out = acc_in;
    if (split) begin
      acc_out[{beat, 3'b000} +: 8] = mem_rdata[{lane, 3'b000} +: 8];
    end else begin
      case (size)
        SIZE_BYTE: acc_out = {24'h0, mem_rdata[{lane, 3'b000} +: 8]};
        SIZE_HALF: acc_out = {16'h0, mem_rdata[{lane[1], 4'b0000} +: 16]};
        default:   acc_out = mem_rdata;
      endcase
    end
  end

  always_comb begin
    case (size)
      SIZE_BYTE: ext_out = {{24{sgn & acc_out[7]}}, acc_out[7:0]};
      SIZE_HALF: ext_out = {{16{sgn & acc_out[15]}}, acc_out[15:0]};
      default:   ext_out = acc_out;   // word ignores sgn
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between the datapath and async_memory.
//   req_*   : request handshake (accepted in IDLE when req_valid=1)
//   rsp_*   : one-cycle completion pulse with load data / error flag
//   mem_*   : registered drive of the memory's addr/data/size/we/re; mem_rdata
//             is the memory's combinational read of mem_addr
// Aligned accesses take one memory beat; misaligned half/word accesses are
// split into 2/4 byte beats when SPLIT_EN=1, otherwise flagged as errors.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter bit SPLIT_EN = 1'b1
)(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_write,
  input  logic        req_signed,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic              split_q, split_d;
  logic [BEAT_W-1:0] beat_q, beat_d, last_q, last_d, beat_nxt;
  logic [31:0]       acc_q, acc_d;
  logic [31:0]       mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic              mem_we_q, mem_we_d, mem_re_q, mem_re_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic [31:0]       acc_nxt, ext_res;
  logic              misal, illegal;

  assign misal    = misaligned(req_addr[1:0], req_size);
  assign illegal  = (req_size == SIZE_ILLEGAL);
  assign beat_nxt = beat_q + 1'b1;

  load_extend u_ext (
    .mem_rdata (mem_rdata),
    .lane      (mem_addr_q[1:0]),
    .beat      (beat_q[1:0]),
    .split     (split_q),
    .size      (req_q.size),
    .sgn       (req_q.sgn),
    .acc_in    (acc_q),
    .acc_out   (acc_nxt),
    .ext_out   (ext_res)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    split_d     = split_q;
    beat_d      = beat_q;
    last_d      = last_q;
    acc_d       = acc_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;
    mem_we_d    = 1'b0;          // strobes only live in ACCESS
    mem_re_d    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d  = '{addr: req_addr, wdata: req_wdata, size: req_size,
                     write: req_write, sgn: req_signed};
          beat_d = '0;
          acc_d  = '0;
          if (illegal || (misal && !SPLIT_EN)) begin
            // No memory traffic: answer directly.
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d     = ST_ACCESS;
            split_d     = misal;
            last_d      = !misal ? 3'd0 : ((req_size == SIZE_WORD) ? 3'd3 : 3'd1);
            mem_addr_d  = req_addr;
            mem_size_d  = misal ? SIZE_BYTE : req_size;
            mem_wdata_d = misal ? {24'h0, req_wdata[7:0]} : req_wdata;
            mem_we_d    = req_write;
            mem_re_d    = !req_write;
          end
        end
      end

      ST_ACCESS: begin
        // The current beat's read data is sampled on this edge.
        acc_d = acc_nxt;
        if (beat_q == last_q) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = req_q.write ? 32'h0 : ext_res;
        end else begin
          beat_d      = beat_nxt;
          // 32-bit add: split beats may carry across words and wrap at 2^32.
          mem_addr_d  = req_q.addr + {29'h0, beat_nxt};
          mem_size_d  = SIZE_BYTE;
          mem_wdata_d = {24'h0, req_q.wdata[{beat_nxt[1:0], 3'b000} +: 8]};
          mem_we_d    = req_q.write;
          mem_re_d    = !req_q.write;
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      split_q     <= 1'b0;
      beat_q      <= '0;
      last_q      <= '0;
      acc_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      split_q     <= split_d;
      beat_q      <= beat_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_size  = mem_size_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a small byte-array memory stands in for
// async_memory (aligned-word combinational read, writes on posedge, unaligned
// half/word writes ignored). Address bits [5:0] index it, so the region at
// 0x10000000 and the 2^32 wrap both land in the same 64 bytes.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_ready, rsp_valid, rsp_err, mem_we, mem_re;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;

  logic        ns_req_valid = 1'b0;
  logic [31:0] ns_req_addr = '0;
  logic [1:0]  ns_req_size = '0;
  logic        ns_req_ready, ns_rsp_valid, ns_rsp_err, ns_mem_we, ns_mem_re;
  logic [31:0] ns_rsp_rdata, ns_mem_addr, ns_mem_wdata;
  logic [1:0]  ns_mem_size;

  always #5 clock = ~clock;

  mem_access_unit #(.SPLIT_EN(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_write(req_write), .req_signed(req_signed), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  mem_access_unit #(.SPLIT_EN(1'b0)) u_ns (
    .clock(clock), .reset_n(reset_n), .req_valid(ns_req_valid), .req_ready(ns_req_ready),
    .req_addr(ns_req_addr), .req_wdata(32'h0), .req_size(ns_req_size),
    .req_write(1'b0), .req_signed(1'b1), .rsp_valid(ns_rsp_valid),
    .rsp_rdata(ns_rsp_rdata), .rsp_err(ns_rsp_err), .mem_addr(ns_mem_addr),
    .mem_wdata(ns_mem_wdata), .mem_size(ns_mem_size), .mem_we(ns_mem_we), .mem_re(ns_mem_re),
    .mem_rdata(32'h0)
  );

  // ---------------- memory model ----------------
  logic [7:0] mem [0:63];
  logic [7:0] img [0:63];
  logic       pl_en = 1'b0;
  logic [5:0] ix, wb;

  assign ix = mem_addr[5:0];
  assign wb = {mem_addr[5:2], 2'b00};
  assign mem_rdata = {mem[wb + 6'd3], mem[wb + 6'd2], mem[wb + 6'd1], mem[wb]};

  always @(posedge clock) begin
    if (pl_en) mem <= img;
    else if (mem_we) begin
      case (mem_size)
        2'd0: mem[ix] <= mem_wdata[7:0];
        2'd1: if (!mem_addr[0]) begin
                mem[ix] <= mem_wdata[7:0]; mem[ix + 6'd1] <= mem_wdata[15:8];
              end
        2'd3: if (mem_addr[1:0] == 2'b00) begin
                mem[ix] <= mem_wdata[7:0];          mem[ix + 6'd1] <= mem_wdata[15:8];
                mem[ix + 6'd2] <= mem_wdata[23:16]; mem[ix + 6'd3] <= mem_wdata[31:24];
              end
        default: ;
      endcase
    end
  end

  // beat monitor: every cycle with a strobe is one memory beat
  int          act_cnt = 0, ns_act = 0;
  logic [31:0] tr_addr [0:63];
  logic [1:0]  tr_size [0:63];
  always @(negedge clock) begin
    if (mem_we || mem_re) begin
      tr_addr[act_cnt % 64] <= mem_addr;
      tr_size[act_cnt % 64] <= mem_size;
      act_cnt <= act_cnt + 1;
    end
    if (ns_mem_we || ns_mem_re) ns_act <= ns_act + 1;
  end

  // ---------------- checking helpers ----------------
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int b);
    return {mem[b + 3], mem[b + 2], mem[b + 1], mem[b]};
  endfunction

  task automatic preload();
    for (int i = 0; i < 64; i++) img[i] = 8'h00;
    {img[3], img[2], img[1], img[0]} = 32'h8899AABB;
    {img[7], img[6], img[5], img[4]} = 32'h44332211;
    img[62] = 8'h5A; img[63] = 8'hC3;
    @(negedge clock); pl_en = 1'b1;
    @(negedge clock); pl_en = 1'b0;
  endtask

  // Present one request; lat = posedges from the accept edge up to the
  // response cycle inclusive.
  task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                        input logic wr, input logic sg,
                        output logic [31:0] rd, output logic er, output int lat);
    bit got = 0;
    rd = 'x; er = 1'bx; lat = 0;
    @(negedge clock);
    req_addr = a; req_wdata = wd; req_size = sz; req_write = wr; req_signed = sg;
    req_valid = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clock); lat++;
      @(negedge clock); req_valid = 1'b0;
      if (rsp_valid) begin got = 1; rd = rsp_rdata; er = rsp_err; end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL timeout: no rsp_valid for addr 0x%08h within 20 cycles", a);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_beats;
  } vec_t;

  vec_t        vecs [10];
  logic [31:0] rd, t32;
  logic        er;
  int          lat, a0;

  initial begin
    vecs[0] = '{"lb_s_1",   32'h10000001, 2'd0, 1'b1, 32'hFFFFFFAA, 1'b0, 2, 1};
    vecs[1] = '{"lhu_2",    32'h10000002, 2'd1, 1'b0, 32'h00008899, 1'b0, 2, 1};
    vecs[2] = '{"lw_3",     32'h10000003, 2'd3, 1'b0, 32'h33221188, 1'b0, 5, 4};
    vecs[3] = '{"lh_s_2",   32'h10000002, 2'd1, 1'b1, 32'hFFFF8899, 1'b0, 2, 1};
    vecs[4] = '{"lbu_3",    32'h10000003, 2'd0, 1'b0, 32'h00000088, 1'b0, 2, 1};
    vecs[5] = '{"lhu_3",    32'h10000003, 2'd1, 1'b0, 32'h00001188, 1'b0, 3, 2};
    vecs[6] = '{"lh_s_1",   32'h10000001, 2'd1, 1'b1, 32'hFFFF99AA, 1'b0, 3, 2};
    vecs[7] = '{"lw_4",     32'h10000004, 2'd3, 1'b0, 32'h44332211, 1'b0, 2, 1};
    vecs[8] = '{"lw_s_0",   32'h10000000, 2'd3, 1'b1, 32'h8899AABB, 1'b0, 2, 1};
    vecs[9] = '{"lw_wrap",  32'hFFFFFFFE, 2'd3, 1'b0, 32'hAABBC35A, 1'b0, 5, 4};

    // reset state
    #12;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_mem_strobes", {30'h0, mem_we, mem_re}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_size", {30'h0, mem_size}, 32'h0);
    @(negedge clock); reset_n = 1'b1;
    preload();

    // table-driven loads
    foreach (vecs[i]) begin
      a0 = act_cnt;
      do_req(vecs[i].addr, 32'h0, vecs[i].size, 1'b0, vecs[i].sgn, rd, er, lat);
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      chk({vecs[i].name, "_err"}, {31'h0, er}, {31'h0, vecs[i].exp_err});
      chk({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
      chk({vecs[i].name, "_beats"}, act_cnt - a0, vecs[i].exp_beats);
    end

    // split word load beat trace: byte beats at consecutive addresses
    a0 = act_cnt;
    do_req(32'h10000003, 32'h0, 2'd3, 1'b0, 1'b0, rd, er, lat);
    for (int b = 0; b < 4; b++) begin
      t32 = 32'h10000003 + b;
      chk($sformatf("lw3_beat%0d_addr", b), tr_addr[(a0 + b) % 64], t32);
      chk($sformatf("lw3_beat%0d_size", b), {30'h0, tr_size[(a0 + b) % 64]}, 32'h0);
    end

    // illegal size: error, no memory traffic
    a0 = act_cnt;
    do_req(32'h10000000, 32'h0, 2'd2, 1'b1, 1'b0, rd, er, lat);
    chk("ill_err", {31'h0, er}, 32'h1);
    chk("ill_rdata", rd, 32'h0);
    chk("ill_beats", act_cnt - a0, 0);

    // misaligned store split across two words
    do_req(32'h10000001, 32'hDEADBEEF, 2'd3, 1'b1, 1'b0, rd, er, lat);
    chk("sw1_err", {31'h0, er}, 32'h0);
    chk("sw1_rdata", rd, 32'h0);
    chk("sw1_lat", lat, 5);
    chk("sw1_word0", word_at(0), 32'hADBEEFBB);
    chk("sw1_word4", word_at(4), 32'h443322DE);

    // aligned half + byte stores, then read back
    do_req(32'h10000008, 32'hFFFF1234, 2'd1, 1'b1, 1'b0, rd, er, lat);
    do_req(32'h1000000B, 32'h0000AB77, 2'd0, 1'b1, 1'b0, rd, er, lat);
    chk("sh_sb_word8", word_at(8), 32'h77001234);
    do_req(32'h10000008, 32'h0, 2'd3, 1'b0, 1'b0, rd, er, lat);
    chk("lw8_rdata", rd, 32'h77001234);

    // SPLIT_EN=0: misaligned half is an error with no memory access
    @(negedge clock);
    ns_req_addr = 32'h10000001; ns_req_size = 2'd1; ns_req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock); ns_req_valid = 1'b0;
    chk("ns_rsp_valid", {31'h0, ns_rsp_valid}, 32'h1);
    chk("ns_rsp_err", {31'h0, ns_rsp_err}, 32'h1);
    chk("ns_rsp_rdata", ns_rsp_rdata, 32'h0);
    repeat (3) @(negedge clock);
    chk("ns_no_access", ns_act, 0);

    // reset in the middle of a split store
    preload();
    @(negedge clock);
    req_addr = 32'h10000001; req_wdata = 32'hDEADBEEF; req_size = 2'd3;
    req_write = 1'b1; req_valid = 1'b1;
    @(posedge clock);                 // accept
    @(negedge clock); req_valid = 1'b0;
    @(posedge clock);                 // beat 0 written
    @(posedge clock);                 // beat 1 written
    @(negedge clock); reset_n = 1'b0;
    #1;
    chk("mrst_ready", {31'h0, req_ready}, 32'h1);
    chk("mrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("mrst_we", {31'h0, mem_we}, 32'h0);
    a0 = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (c == 1) reset_n = 1'b1;
      if (rsp_valid || mem_we) a0++;
    end
    chk("mrst_no_rsp", a0, 0);
    chk("mrst_word0", word_at(0), 32'h88BEEFBB);
    chk("mrst_word4", word_at(4), 32'h44332211);

    // back-to-back sw then lw with req_valid held high
    begin
      int nresp = 0, cyc = 0, t1 = 0, t2 = 0;
      @(negedge clock);
      req_addr = 32'h10000010; req_wdata = 32'hCAFEF00D; req_size = 2'd3;
      req_write = 1'b1; req_signed = 1'b0; req_valid = 1'b1;
      for (int c = 0; c < 30 && nresp < 2; c++) begin
        @(posedge clock); cyc++;
        @(negedge clock);
        if (c == 0) begin req_write = 1'b0; req_wdata = 32'h0; end
        if (rsp_valid) begin
          nresp++;
          if (nresp == 1) t1 = cyc;
          else begin t2 = cyc; rd = rsp_rdata; er = rsp_err; req_valid = 1'b0; end
        end
      end
      req_valid = 1'b0;
      chk("b2b_nresp", nresp, 2);
      chk("b2b_rdata", rd, 32'hCAFEF00D);
      chk("b2b_err", {31'h0, er}, 32'h0);
      chk("b2b_spacing", t2 - t1, 3);
    end

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
